// File: rtl/cpu8_pkg.sv
// Shared constants and types for the 8-bit teaching CPU execution core.
package cpu8_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned DM_DEPTH = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/cpu8_dmem.sv
// 256x8 data memory: synchronous write, asynchronous read, no bypass.
// Optional macro DMEM_RESET_CLEAR_EN: reset asynchronously clears every location.
module cpu8_dmem
  import cpu8_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  data_t mem [DM_DEPTH];

`ifdef DMEM_RESET_CLEAR_EN
  // Write port; reset wipes the whole array to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DM_DEPTH; i++) begin
        mem[addr_t'(i)] <= '0;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end
`else
  // Write port; contents survive reset, but writes are suppressed while it is held.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem[addr] <= wdata;
    end
  end
`endif

  // Asynchronous read: old data before a write edge, new data after it.
  always_comb begin
    rdata = mem[addr];
  end

endmodule

// File: rtl/cpu8_alu_flag_dmem.sv
// Execution core: combinational 8-bit adder, registered carry flag, data memory.
// Optional macro DMEM_RESET_CLEAR_EN (handled in cpu8_dmem).
module cpu8_alu_flag_dmem
  import cpu8_pkg::*;
(
  input  logic              CK,
  input  logic              RST,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic              dm_we,
  output logic [DATA_W-1:0] alu_sum,
  output logic              carry,
  output logic              carry_q,
  output logic [DATA_W-1:0] dm_rdata
);

  logic [DATA_W:0] sum_ext;

  // 9-bit unsigned add; the top bit is the carry-out, the rest wraps mod 256.
  always_comb begin
    sum_ext = {1'b0, alu_a} + {1'b0, alu_b};
    alu_sum = sum_ext[DATA_W-1:0];
    carry   = sum_ext[DATA_W];
  end

  // Carry flag for conditional jumps; cleared asynchronously by reset.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry;
    end
  end

  cpu8_dmem u_dmem (
    .clk   (CK),
    .rst   (RST),
    .we    (dm_we),
    .addr  (dm_addr),
    .wdata (alu_sum),
    .rdata (dm_rdata)
  );

endmodule

// File: tb/tb_cpu8_alu_flag_dmem.sv
// Directed self-checking bench for cpu8_alu_flag_dmem.
module tb_cpu8_alu_flag_dmem;

  logic       CK;
  logic       RST;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] dm_addr;
  logic       dm_we;
  logic [7:0] alu_sum;
  logic       carry;
  logic       carry_q;
  logic [7:0] dm_rdata;

  int vectors;
  int miscompares;

  cpu8_alu_flag_dmem dut (
    .CK       (CK),
    .RST      (RST),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .dm_addr  (dm_addr),
    .dm_we    (dm_we),
    .alu_sum  (alu_sum),
    .carry    (carry),
    .carry_q  (carry_q),
    .dm_rdata (dm_rdata)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] addr, input logic we);
    alu_a   = a;
    alu_b   = b;
    dm_addr = addr;
    dm_we   = we;
    #1;
  endtask

  logic [7:0] exp_after_rst7;
  logic [7:0] exp_after_rst3;
  logic [7:0] exp_after_rst255;

  initial begin
    vectors     = 0;
    miscompares = 0;
`ifdef DMEM_RESET_CLEAR_EN
    exp_after_rst7   = 8'h00;
    exp_after_rst3   = 8'h00;
    exp_after_rst255 = 8'h00;
`else
    exp_after_rst7   = 8'h55;
    exp_after_rst3   = 8'd15;
    exp_after_rst255 = 8'h7F;
`endif

    RST = 1'b1;
    drive(8'd0, 8'd0, 8'd0, 1'b0);
    #2;
    check("reset_carry_q", {15'd0, carry_q}, 16'd0);
    @(negedge CK);
    RST = 1'b0;

    // Seed addr 7 with 0x55, then set the carry flag.
    drive(8'h50, 8'h05, 8'd7, 1'b1);
    tick();
    drive(8'd200, 8'd100, 8'd7, 1'b0);
    tick();
    check("seed_carry_q", {15'd0, carry_q}, 16'd1);
    check("seed_mem7", {8'd0, dm_rdata}, 16'h0055);

    // Async reset drops carry_q with no clock edge; write under reset is blocked.
    @(negedge CK);
    RST = 1'b1;
    #1;
    check("async_rst_carry_q", {15'd0, carry_q}, 16'd0);
    drive(8'd1, 8'd2, 8'd7, 1'b1);
    tick();
    check("rst_hold_carry_q", {15'd0, carry_q}, 16'd0);
    check("rst_blocks_write", {8'd0, dm_rdata}, {8'd0, exp_after_rst7});
    @(negedge CK);
    RST = 1'b0;
    drive(8'd0, 8'd0, 8'd0, 1'b0);

    // Plain addition, no carry.
    drive(8'd20, 8'd40, 8'd0, 1'b0);
    check("sum_20_40", {8'd0, alu_sum}, 16'd60);
    check("carry_20_40", {15'd0, carry}, 16'd0);
    tick();
    check("carry_q_20_40", {15'd0, carry_q}, 16'd0);

    // Overflow cases.
    @(negedge CK);
    drive(8'd200, 8'd100, 8'd0, 1'b0);
    check("sum_200_100", {8'd0, alu_sum}, 16'd44);
    check("carry_200_100", {15'd0, carry}, 16'd1);
    check("carry_q_pre_edge", {15'd0, carry_q}, 16'd0);
    tick();
    check("carry_q_200_100", {15'd0, carry_q}, 16'd1);
    @(negedge CK);
    drive(8'd255, 8'd1, 8'd0, 1'b0);
    check("sum_255_1", {8'd0, alu_sum}, 16'd0);
    check("carry_255_1", {15'd0, carry}, 16'd1);
    drive(8'd255, 8'd255, 8'd0, 1'b0);
    check("sum_255_255", {8'd0, alu_sum}, 16'd254);
    check("carry_255_255", {15'd0, carry}, 16'd1);
    drive(8'd127, 8'd128, 8'd0, 1'b0);
    check("sum_127_128", {8'd0, alu_sum}, 16'd255);
    check("carry_127_128", {15'd0, carry}, 16'd0);
    tick();
    check("carry_q_cleared", {15'd0, carry_q}, 16'd0);

    // Memory write of the ALU result, then hold with dm_we=0.
    @(negedge CK);
    drive(8'd10, 8'd5, 8'd3, 1'b1);
    tick();
    check("mem3_write", {8'd0, dm_rdata}, 16'd15);
    @(negedge CK);
    drive(8'd99, 8'd0, 8'd3, 1'b0);
    tick();
    check("mem3_no_we", {8'd0, dm_rdata}, 16'd15);

    // Read-during-write: old value before the edge, new value after.
    @(negedge CK);
    drive(8'h10, 8'h01, 8'd9, 1'b1);
    tick();
    @(negedge CK);
    drive(8'h20, 8'h02, 8'd9, 1'b1);
    check("rdw_old", {8'd0, dm_rdata}, 16'h0011);
    tick();
    check("rdw_new", {8'd0, dm_rdata}, 16'h0022);

    // Extreme addresses, then sweep back for aliasing.
    @(negedge CK);
    drive(8'h7F, 8'h00, 8'd255, 1'b1);
    tick();
    @(negedge CK);
    drive(8'h00, 8'h01, 8'd0, 1'b1);
    tick();
    @(negedge CK);
    drive(8'h00, 8'h00, 8'd255, 1'b0);
    check("sweep_255", {8'd0, dm_rdata}, 16'h007F);
    drive(8'h00, 8'h00, 8'd0, 1'b0);
    check("sweep_0", {8'd0, dm_rdata}, 16'h0001);
    drive(8'h00, 8'h00, 8'd3, 1'b0);
    check("sweep_3", {8'd0, dm_rdata}, 16'd15);
    drive(8'h00, 8'h00, 8'd9, 1'b0);
    check("sweep_9", {8'd0, dm_rdata}, 16'h0022);

    // Reset pulse between edges: memory retained unless clear-on-reset is built in.
    RST = 1'b1;
    #2;
    RST = 1'b0;
    drive(8'h00, 8'h00, 8'd3, 1'b0);
    check("post_rst_mem3", {8'd0, dm_rdata}, {8'd0, exp_after_rst3});
    drive(8'h00, 8'h00, 8'd255, 1'b0);
    check("post_rst_mem255", {8'd0, dm_rdata}, {8'd0, exp_after_rst255});
    check("post_rst_carry_q", {15'd0, carry_q}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #20000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
